team_06_sram_arbiter: RTL and testbench
=======================================

# team_06_sram_arbiter

Two-requester, round-robin arbiter that shares the single user port of the team's Wishbone manager between the audio delay-line read/write engine (requester 0) and a second SRAM client such as the ESP playback buffer (requester 1). Each requester issues single-cycle read or write strobes. The arbiter captures them, serialises them onto the manager's one-transaction-at-a-time port, and returns a done pulse plus read data to the originating requester. It sits between the requester blocks and the Wishbone manager inside the team top.

## Interface
Parameters:
- `START_WAIT`, default 4: maximum cycles to wait for `mgr_busy` to rise after a strobe before treating the transaction as complete.
- `TIMEOUT_CYCLES`, default 255: watchdog limit. Used only with the timeout macro.

Ports (`reqN` is repeated for N = 0, 1):
- `clk`  in  1  system clock (hwclk). This is the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `reqN_write`  in  1  single-cycle write strobe.
- `reqN_read`  in  1  single-cycle read strobe.
- `reqN_adr`  in  32  byte address, sampled on the strobe.
- `reqN_wdat`  in  32  write data, sampled on the strobe.
- `reqN_sel`  in  4  byte selects, sampled on the strobe.
- `reqN_pending`  out  1  high from the cycle after an accepted strobe until the cycle of `reqN_done`.
- `reqN_done`  out  1  one-cycle completion pulse.
- `reqN_rdat`  out  32  read data. Valid while `reqN_done` is high and held until the next completion for that requester.
- `reqN_err`  out  1  timeout flag, pulses with `reqN_done`.
- `mgr_adr`  out  32  address to the manager `ADR_I`.
- `mgr_wdat`  out  32  write data to the manager `CPU_DAT_I`.
- `mgr_sel`  out  4  byte selects to the manager `SEL_I`.
- `mgr_write`  out  1  write strobe to the manager `WRITE_I`.
- `mgr_read`  out  1  read strobe to the manager `READ_I`.
- `mgr_rdat`  in  32  read data from the manager `CPU_DAT_O`.
- `mgr_busy`  in  1  busy flag from the manager `BUSY_O`.

## Operation
- Each requester has one slot holding: pending flag, op (R/W), adr, wdat, sel.
- A strobe is accepted only when that requester's slot is empty. A strobe arriving while the slot is pending is dropped.
- If write and read are strobed in the same cycle, write is accepted and read is dropped.
- Arbitration uses a `last_grant` register, reset to 1. When both slots are pending, grant goes to the requester that was not granted last. When only one is pending, it is granted.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE, DONE.
- IDLE: if any slot is pending, latch the grant, update `last_grant`, and go to ISSUE.
- ISSUE: drive `mgr_write` or `mgr_read` high for exactly one cycle, then go to WAIT_START.
- WAIT_START: go to WAIT_DONE when `mgr_busy`=1. If `mgr_busy` is still 0 after `START_WAIT` cycles in this state, go to DONE.
- WAIT_DONE: when `mgr_busy`=0, capture `mgr_rdat` (reads only) and go to DONE.
- DONE: pulse `reqN_done` for the granted requester, clear its pending flag, and go to IDLE.
- `mgr_adr`, `mgr_wdat` and `mgr_sel` come from the granted slot. They are held stable from ISSUE through DONE and read 0 in IDLE.
- A slot may accept a new strobe in its DONE cycle. That strobe is pending from the next cycle.
- For writes, `reqN_rdat` keeps its previous value.

## Timing
- Reset: every output is 0, the FSM is in IDLE, both slots are empty, and `last_grant`=1. Reset mid-transaction drops all pending work and deasserts the manager strobes at that edge. No done pulse is issued.
- Strobe at cycle T:
  - pending from T+1;
  - IDLE decides at T+1;
  - manager strobe at T+2;
  - if busy rises at T+3 and falls at cycle B, `reqN_done` and `reqN_rdat` are valid at B+1.
- Minimum strobe-to-done is 5 cycles.
- The manager sees at most one strobe per transaction, and never a strobe while `mgr_busy`=1.
- After DONE, the other pending requester reaches ISSUE 2 cycles later (DONE → IDLE → ISSUE).

## Configuration
- `TEAM_06_SRAM_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT_START and WAIT_DONE. It clears on entry to ISSUE.
  - When it reaches `TIMEOUT_CYCLES` while still in WAIT_DONE, the FSM goes to DONE with `reqN_rdat`=32'h0 and `reqN_err`=1 for that pulse.
- Not defined:
  - No counter is built; WAIT_DONE waits indefinitely.
  - Both `reqN_err` outputs are tied to 0.

## Test plan
- Single read on req0 at `adr`=0x3300_0010, with the manager model raising busy for 6 cycles and returning 0xDEAD_BEEF:
  - `mgr_read` pulses once with `mgr_adr`=0x3300_0010;
  - `req0_done` pulses with `req0_rdat`=0xDEAD_BEEF;
  - `req0_err`=0.
- req0 write and req1 read strobed in the same cycle after reset:
  - req0 is served first (`last_grant` resets to 1);
  - req1 is issued 2 cycles after `req0_done`;
  - 3 more simultaneous pairs alternate req1, req0, req1.
- req0 strobes a second write while `req0_pending`=1:
  - the second strobe is dropped;
  - exactly one `mgr_write` pulse and one `req0_done`.
- Manager never raises busy, with `START_WAIT`=4:
  - `req1_done` pulses 4 cycles after WAIT_START is entered;
  - `req1_rdat` is unchanged.
- Busy held high forever, with the macro defined and `TIMEOUT_CYCLES`=20:
  - `req0_done` and `req0_err` both pulse;
  - `req0_rdat`=0.
  - Without the macro, no done pulse appears within 1000 cycles.
- `rst` asserted during WAIT_DONE:
  - next cycle all outputs are 0 and both pending flags are cleared;
  - a fresh req1 read then completes normally.

Source files
------------

// File: rtl/team_06_sram_arbiter.sv
// team_06_sram_arbiter: round-robin arbiter sharing the Wishbone manager user port between two single-slot SRAM requesters; define TEAM_06_SRAM_ARB_TIMEOUT_EN to add the WAIT_DONE watchdog
module team_06_sram_arbiter #(
  parameter int START_WAIT = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_write,
  input  logic        req0_read,
  input  logic [31:0] req0_adr,
  input  logic [31:0] req0_wdat,
  input  logic [3:0]  req0_sel,
  output logic        req0_pending,
  output logic        req0_done,
  output logic [31:0] req0_rdat,
  output logic        req0_err,
  input  logic        req1_write,
  input  logic        req1_read,
  input  logic [31:0] req1_adr,
  input  logic [31:0] req1_wdat,
  input  logic [3:0]  req1_sel,
  output logic        req1_pending,
  output logic        req1_done,
  output logic [31:0] req1_rdat,
  output logic        req1_err,
  output logic [31:0] mgr_adr,
  output logic [31:0] mgr_wdat,
  output logic [3:0]  mgr_sel,
  output logic        mgr_write,
  output logic        mgr_read,
  input  logic [31:0] mgr_rdat,
  input  logic        mgr_busy
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, DONE} state_t;
  state_t state;
  logic [1:0] wr, rd, acc, pend, op_w, done;
  logic [1:0][31:0] a_in, d_in, adr, wdat, rdat;
  logic [1:0][3:0] s_in, sel;
  logic gnt, nxt, last_grant, op;
  logic [31:0] sw;
  assign wr = {req1_write, req0_write};
  assign rd = {req1_read, req0_read};
  assign a_in = {req1_adr, req0_adr};
  assign d_in = {req1_wdat, req0_wdat};
  assign s_in = {req1_sel, req0_sel};
  assign nxt = &pend ? ~last_grant : pend[1];
  assign acc = (wr | rd) & (~pend | (state == DONE ? 2'b01 << gnt : 2'b00));
  assign {req1_pending, req0_pending} = pend;
  assign {req1_done, req0_done} = done;
  assign req0_rdat = rdat[0];
  assign req1_rdat = rdat[1];
`ifdef TEAM_06_SRAM_ARB_TIMEOUT_EN
  logic [1:0] err;
  logic [31:0] tcnt;
  assign {req1_err, req0_err} = err;
`else
  assign {req1_err, req0_err} = {2{TIMEOUT_CYCLES < 0}};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend <= '0;
      op_w <= '0;
      done <= '0;
      adr <= '0;
      wdat <= '0;
      sel <= '0;
      rdat <= '0;
      gnt <= 1'b0;
      last_grant <= 1'b1;
      op <= 1'b0;
      sw <= '0;
      mgr_adr <= '0;
      mgr_wdat <= '0;
      mgr_sel <= '0;
      mgr_write <= 1'b0;
      mgr_read <= 1'b0;
`ifdef TEAM_06_SRAM_ARB_TIMEOUT_EN
      err <= '0;
      tcnt <= '0;
`endif
    end else begin
      done <= '0;
      mgr_write <= 1'b0;
      mgr_read <= 1'b0;
`ifdef TEAM_06_SRAM_ARB_TIMEOUT_EN
      err <= '0;
`endif
      case (state)
        IDLE: if (|pend) begin
          gnt <= nxt;
          last_grant <= nxt;
          op <= op_w[nxt];
          mgr_adr <= adr[nxt];
          mgr_wdat <= wdat[nxt];
          mgr_sel <= sel[nxt];
          mgr_write <= op_w[nxt];
          mgr_read <= ~op_w[nxt];
          sw <= '0;
`ifdef TEAM_06_SRAM_ARB_TIMEOUT_EN
          tcnt <= '0;
`endif
          state <= ISSUE;
        end
        ISSUE: state <= WAIT_START;
        WAIT_START: begin
`ifdef TEAM_06_SRAM_ARB_TIMEOUT_EN
          tcnt <= tcnt + 1;
`endif
          if (mgr_busy) state <= WAIT_DONE;
          else if (sw == 32'(START_WAIT - 1)) begin
            state <= DONE;
            done[gnt] <= 1'b1;
          end else sw <= sw + 1;
        end
        WAIT_DONE: begin
`ifdef TEAM_06_SRAM_ARB_TIMEOUT_EN
          tcnt <= tcnt + 1;
`endif
          if (!mgr_busy) begin
            state <= DONE;
            done[gnt] <= 1'b1;
            if (!op) rdat[gnt] <= mgr_rdat;
          end
`ifdef TEAM_06_SRAM_ARB_TIMEOUT_EN
          else if (tcnt >= 32'(TIMEOUT_CYCLES)) begin
            state <= DONE;
            done[gnt] <= 1'b1;
            err[gnt] <= 1'b1;
            rdat[gnt] <= '0;
          end
`endif
        end
        DONE: begin
          pend[gnt] <= 1'b0;
          mgr_adr <= '0;
          mgr_wdat <= '0;
          mgr_sel <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      for (int i = 0; i < 2; i++) if (acc[i]) begin
        pend[i] <= 1'b1;
        op_w[i] <= wr[i];
        adr[i] <= a_in[i];
        wdat[i] <= d_in[i];
        sel[i] <= s_in[i];
      end
    end
  end
endmodule

// File: tb/tb_team_06_sram_arbiter.sv
// tb_team_06_sram_arbiter: directed self-checking bench for the two-requester SRAM arbiter
module tb_team_06_sram_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_write = 1'b0, req0_read = 1'b0, req1_write = 1'b0, req1_read = 1'b0;
  logic [31:0] req0_adr = '0, req0_wdat = '0, req1_adr = '0, req1_wdat = '0;
  logic [3:0] req0_sel = '0, req1_sel = '0;
  logic req0_pending, req0_done, req0_err, req1_pending, req1_done, req1_err;
  logic [31:0] req0_rdat, req1_rdat, mgr_adr, mgr_wdat;
  logic [3:0] mgr_sel;
  logic mgr_write, mgr_read;
  logic [31:0] rdata = '0;
  logic busy_m = 1'b0;
  bit clr = 1'b0;
  int mode = 0, blen = 1, bcnt = 0, cyc = 0, checks = 0, errors = 0, viol = 0;
  int d0_cnt = 0, d1_cnt = 0, d0_cyc = 0, d1_cyc = 0;
  logic [31:0] d0_rdat, d1_rdat;
  logic d0_err, d1_err;
  logic [31:0] iss_adr[$], iss_wdat[$];
  logic [3:0] iss_sel[$];
  int iss_cyc[$];
  bit iss_wr[$];

  team_06_sram_arbiter #(.START_WAIT(4), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst),
    .req0_write(req0_write), .req0_read(req0_read), .req0_adr(req0_adr), .req0_wdat(req0_wdat), .req0_sel(req0_sel),
    .req0_pending(req0_pending), .req0_done(req0_done), .req0_rdat(req0_rdat), .req0_err(req0_err),
    .req1_write(req1_write), .req1_read(req1_read), .req1_adr(req1_adr), .req1_wdat(req1_wdat), .req1_sel(req1_sel),
    .req1_pending(req1_pending), .req1_done(req1_done), .req1_rdat(req1_rdat), .req1_err(req1_err),
    .mgr_adr(mgr_adr), .mgr_wdat(mgr_wdat), .mgr_sel(mgr_sel), .mgr_write(mgr_write), .mgr_read(mgr_read),
    .mgr_rdat(rdata), .mgr_busy(busy_m)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (clr) busy_m <= 1'b0;
    else if (mgr_read || mgr_write) begin
      if (mode != 1) busy_m <= 1'b1;
      bcnt <= blen - 1;
    end else if (busy_m && mode == 0) begin
      if (bcnt == 0) busy_m <= 1'b0;
      else bcnt <= bcnt - 1;
    end
  end

  always @(negedge clk) begin
    if (req0_done) begin d0_cnt++; d0_cyc = cyc; d0_rdat = req0_rdat; d0_err = req0_err; end
    if (req1_done) begin d1_cnt++; d1_cyc = cyc; d1_rdat = req1_rdat; d1_err = req1_err; end
    if (mgr_read || mgr_write) begin
      iss_adr.push_back(mgr_adr);
      iss_wdat.push_back(mgr_wdat);
      iss_sel.push_back(mgr_sel);
      iss_cyc.push_back(cyc);
      iss_wr.push_back(mgr_write);
      if (busy_m) viol++;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; clr = 1'b0;
  endtask

  task automatic strobe(input int r, input bit w, input logic [31:0] a, input logic [31:0] d, output int t);
    @(posedge clk); #1;
    t = cyc;
    if (r != 0) begin req1_write = w; req1_read = !w; req1_adr = a; req1_wdat = d; end
    else begin req0_write = w; req0_read = !w; req0_adr = a; req0_wdat = d; end
    @(posedge clk); #1;
    req0_write = 0; req0_read = 0; req1_write = 0; req1_read = 0;
  endtask

  task automatic wait_done(input int r, input int base, input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk); #1;
      if ((r != 0 ? d1_cnt : d0_cnt) != base) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({req0_pending, req1_pending, req0_done, req1_done, req0_err, req1_err, mgr_write, mgr_read} !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000000", {req0_pending, req1_pending, req0_done, req1_done, req0_err, req1_err, mgr_write, mgr_read}); end
    checks++; if (req0_rdat !== 32'h0) begin errors++; $display("FAIL reset_rdat0: got %h expected 0", req0_rdat); end
    checks++; if (req1_rdat !== 32'h0) begin errors++; $display("FAIL reset_rdat1: got %h expected 0", req1_rdat); end
    checks++; if (mgr_adr !== 32'h0) begin errors++; $display("FAIL reset_mgr_adr: got %h expected 0", mgr_adr); end
    checks++; if (mgr_wdat !== 32'h0) begin errors++; $display("FAIL reset_mgr_wdat: got %h expected 0", mgr_wdat); end
    checks++; if (mgr_sel !== 4'h0) begin errors++; $display("FAIL reset_mgr_sel: got %h expected 0", mgr_sel); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    int t, b0, n;
    bit ok;
    mode = 0; blen = 6; rdata = 32'hDEAD_BEEF; req0_sel = 4'hF; req1_sel = 4'h3;
    b0 = d0_cnt; n = iss_adr.size();
    strobe(0, 0, 32'h3300_0010, 32'h0, t);
    @(negedge clk);
    checks++; if (req0_pending !== 1'b1) begin errors++; $display("FAIL rd_pending: got %b expected 1", req0_pending); end
    wait_done(0, b0, 40, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rd_done_seen: got %b expected 1", ok); end
    checks++; if (d0_cyc !== t + 10) begin errors++; $display("FAIL rd_done_cyc: got %0d expected %0d", d0_cyc, t + 10); end
    checks++; if (d0_rdat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdat: got %h expected deadbeef", d0_rdat); end
    checks++; if (d0_err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", d0_err); end
    checks++; if (iss_adr.size() - n !== 1) begin errors++; $display("FAIL rd_strobes: got %0d expected 1", iss_adr.size() - n); end
    else begin
      checks++; if (iss_adr[n] !== 32'h3300_0010) begin errors++; $display("FAIL rd_mgr_adr: got %h expected 33000010", iss_adr[n]); end
      checks++; if (iss_cyc[n] !== t + 2) begin errors++; $display("FAIL rd_issue_cyc: got %0d expected %0d", iss_cyc[n], t + 2); end
      checks++; if (iss_wr[n] !== 1'b0) begin errors++; $display("FAIL rd_is_read: got %b expected 0", iss_wr[n]); end
      checks++; if (iss_sel[n] !== 4'hF) begin errors++; $display("FAIL rd_mgr_sel: got %h expected f", iss_sel[n]); end
    end
    @(negedge clk);
    checks++; if ({req0_pending, req0_done} !== 2'b00) begin errors++; $display("FAIL rd_after_done: got %b expected 00", {req0_pending, req0_done}); end
  endtask

  task automatic test_round_robin();
    int t, b0, b1, n, s0, s1, first_d0;
    do_reset();
    mode = 0; blen = 2; rdata = 32'h0BAD_F00D;
    b0 = d0_cnt; b1 = d1_cnt; n = iss_adr.size(); first_d0 = -1;
    @(negedge clk);
    t = cyc;
    req0_write = 1; req0_adr = 32'h100; req0_wdat = 32'hA0;
    req1_read = 1; req1_adr = 32'h200;
    s0 = 1; s1 = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      req0_write = 0; req1_read = 0;
      if (req0_done && first_d0 < 0) first_d0 = cyc;
      if (req0_done && s0 < 4) begin req0_write = 1; req0_adr = 32'h100 + 32'(4 * s0); req0_wdat = 32'hA0 + 32'(s0); s0++; end
      if (req1_done && s1 < 4) begin req1_read = 1; req1_adr = 32'h200 + 32'(4 * s1); s1++; end
      #1;
      if (d0_cnt - b0 == 4 && d1_cnt - b1 == 4) break;
    end
    req0_write = 0; req1_read = 0;
    checks++; if (d0_cnt - b0 !== 4) begin errors++; $display("FAIL rr_done0_count: got %0d expected 4", d0_cnt - b0); end
    checks++; if (d1_cnt - b1 !== 4) begin errors++; $display("FAIL rr_done1_count: got %0d expected 4", d1_cnt - b1); end
    checks++; if (first_d0 !== t + 6) begin errors++; $display("FAIL rr_first_done_cyc: got %0d expected %0d", first_d0, t + 6); end
    checks++; if (d1_rdat !== 32'h0BAD_F00D) begin errors++; $display("FAIL rr_rdat1: got %h expected 0badf00d", d1_rdat); end
    checks++; if (iss_adr.size() - n !== 8) begin errors++; $display("FAIL rr_strobes: got %0d expected 8", iss_adr.size() - n); end
    else begin
      checks++; if (iss_cyc[n] !== t + 2) begin errors++; $display("FAIL rr_first_issue_cyc: got %0d expected %0d", iss_cyc[n], t + 2); end
      checks++; if (iss_cyc[n + 1] !== first_d0 + 2) begin errors++; $display("FAIL rr_second_issue_cyc: got %0d expected %0d", iss_cyc[n + 1], first_d0 + 2); end
      checks++; if (iss_wdat[n] !== 32'hA0) begin errors++; $display("FAIL rr_first_wdat: got %h expected a0", iss_wdat[n]); end
      for (int k = 0; k < 8; k++) begin
        checks++; if (iss_adr[n + k] !== ((k % 2 == 1) ? 32'h200 : 32'h100) + 32'(4 * (k / 2))) begin errors++; $display("FAIL rr_order_%0d: got %h expected %h", k, iss_adr[n + k], ((k % 2 == 1) ? 32'h200 : 32'h100) + 32'(4 * (k / 2))); end
        checks++; if (iss_wr[n + k] !== (k % 2 == 0)) begin errors++; $display("FAIL rr_op_%0d: got %b expected %b", k, iss_wr[n + k], k % 2 == 0); end
      end
    end
  endtask

  task automatic test_drop();
    int t, t2, b0, n;
    bit ok;
    mode = 0; blen = 2;
    b0 = d0_cnt; n = iss_adr.size();
    strobe(0, 1, 32'h400, 32'h11, t);
    @(negedge clk);
    checks++; if (req0_pending !== 1'b1) begin errors++; $display("FAIL drop_pending: got %b expected 1", req0_pending); end
    strobe(0, 1, 32'h404, 32'h22, t2);
    wait_done(0, b0, 40, ok);
    repeat (20) @(negedge clk);
    #1;
    checks++; if (d0_cnt - b0 !== 1) begin errors++; $display("FAIL drop_done_count: got %0d expected 1", d0_cnt - b0); end
    checks++; if (iss_adr.size() - n !== 1) begin errors++; $display("FAIL drop_strobes: got %0d expected 1", iss_adr.size() - n); end
    else begin
      checks++; if (iss_adr[n] !== 32'h400) begin errors++; $display("FAIL drop_adr: got %h expected 400", iss_adr[n]); end
      checks++; if (iss_wdat[n] !== 32'h11) begin errors++; $display("FAIL drop_wdat: got %h expected 11", iss_wdat[n]); end
    end
  endtask

  task automatic test_start_wait();
    int t, b1, n;
    bit ok;
    mode = 1; rdata = 32'h1234_5678;
    b1 = d1_cnt; n = iss_adr.size();
    strobe(1, 0, 32'h500, 32'h0, t);
    wait_done(1, b1, 40, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sw_done_seen: got %b expected 1", ok); end
    checks++; if (d1_cyc !== t + 7) begin errors++; $display("FAIL sw_done_cyc: got %0d expected %0d", d1_cyc, t + 7); end
    checks++; if (d1_rdat !== 32'h0BAD_F00D) begin errors++; $display("FAIL sw_rdat_held: got %h expected 0badf00d", d1_rdat); end
    checks++; if (d1_err !== 1'b0) begin errors++; $display("FAIL sw_err: got %b expected 0", d1_err); end
    checks++; if (iss_adr.size() - n !== 1) begin errors++; $display("FAIL sw_strobes: got %0d expected 1", iss_adr.size() - n); end
  endtask

  task automatic test_timeout();
    int t, b0;
    bit ok;
    mode = 2; rdata = 32'h55AA_55AA;
    b0 = d0_cnt;
    strobe(0, 0, 32'h600, 32'h0, t);
`ifdef TEAM_06_SRAM_ARB_TIMEOUT_EN
    wait_done(0, b0, 100, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_done_seen: got %b expected 1", ok); end
    checks++; if (d0_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", d0_err); end
    checks++; if (d0_rdat !== 32'h0) begin errors++; $display("FAIL to_rdat: got %h expected 0", d0_rdat); end
`else
    wait_done(0, b0, 1000, ok);
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL to_no_done: got %b expected 0", ok); end
    checks++; if (req0_pending !== 1'b1) begin errors++; $display("FAIL to_still_pending: got %b expected 1", req0_pending); end
`endif
  endtask

  task automatic test_reset_mid();
    int t, t2, b0, b1;
    bit ok;
    do_reset();
    mode = 0; blen = 10; rdata = 32'h7777_0000;
    b0 = d0_cnt;
    strobe(0, 0, 32'h680, 32'h0, t);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if ({req0_pending, mgr_adr} !== {1'b1, 32'h680}) begin errors++; $display("FAIL rm_before: got %b/%h expected 1/00000680", req0_pending, mgr_adr); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({req0_pending, req1_pending, req0_done, req1_done, req0_err, req1_err, mgr_write, mgr_read} !== 8'h00) begin errors++; $display("FAIL rm_ctrl: got %b expected 00000000", {req0_pending, req1_pending, req0_done, req1_done, req0_err, req1_err, mgr_write, mgr_read}); end
    checks++; if ({req0_rdat, req1_rdat} !== 64'h0) begin errors++; $display("FAIL rm_rdat: got %h expected 0", {req0_rdat, req1_rdat}); end
    checks++; if ({mgr_adr, mgr_wdat, mgr_sel} !== 68'h0) begin errors++; $display("FAIL rm_mgr: got %h expected 0", {mgr_adr, mgr_wdat, mgr_sel}); end
    repeat (20) @(negedge clk);
    #1;
    checks++; if (d0_cnt !== b0) begin errors++; $display("FAIL rm_no_done: got %0d expected %0d", d0_cnt, b0); end
    blen = 3; rdata = 32'hCAFE_0001;
    b1 = d1_cnt;
    strobe(1, 0, 32'h700, 32'h0, t2);
    wait_done(1, b1, 40, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rm_fresh_seen: got %b expected 1", ok); end
    checks++; if (d1_cyc !== t2 + 7) begin errors++; $display("FAIL rm_fresh_cyc: got %0d expected %0d", d1_cyc, t2 + 7); end
    checks++; if (d1_rdat !== 32'hCAFE_0001) begin errors++; $display("FAIL rm_fresh_rdat: got %h expected cafe0001", d1_rdat); end
    checks++; if (d1_err !== 1'b0) begin errors++; $display("FAIL rm_fresh_err: got %b expected 0", d1_err); end
    checks++; if (iss_adr[$] !== 32'h700) begin errors++; $display("FAIL rm_fresh_adr: got %h expected 700", iss_adr[$]); end
  endtask

  task automatic test_protocol();
    checks++; if (viol !== 0) begin errors++; $display("FAIL strobe_while_busy: got %0d expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_drop();
    test_start_wait();
    test_timeout();
    test_reset_mid();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
